// File: rtl/wport_arb_pkg.sv
// Shared types and constants for the four-requester write-port arbiter.
package wport_arb_pkg;

  localparam int unsigned N_REQ    = 4;
  localparam int unsigned LOCK_MAX = 4;
  localparam int unsigned CNT_W    = $clog2(LOCK_MAX);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first asserted request at or after ptr (mod 4).
module rr_pick4
  import wport_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       ptr,
  output logic             valid,
  output logic [1:0]       winner
);

  logic [1:0] idx;

  // Scan from the farthest offset down so the nearest request to ptr wins.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned i = N_REQ; i > 0; i--) begin
      idx = ptr + 2'(i - 1);
      if (req[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/wport_arbiter_4.sv
// Round-robin write-port arbiter for four requesters with registered outputs.
// Optional grant locking is enabled by defining WPORT_ARB_LOCK_EN.
module wport_arbiter_4
  import wport_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        lock,
  input  logic [N_REQ*ADDR_W-1:0] addr_in,
  input  logic [N_REQ*DATA_W-1:0] data_in,
  output logic [N_REQ-1:0]        gnt,
  output logic [1:0]              sel,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [DATA_W-1:0]       wr_data,
  output logic                    busy
);

  state_e            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [1:0]        sel_q, sel_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              busy_q, busy_d;

  logic              pick_valid;
  logic [1:0]        pick_idx;
  logic [1:0]        mux_idx;
  logic              hold;

`ifdef WPORT_ARB_LOCK_EN
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`else
  logic              unused_lock;
  assign unused_lock = ^lock;
`endif

  rr_pick4 u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = '0;
    sel_d     = sel_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = 1'b0;
    hold      = 1'b0;
    mux_idx   = pick_idx;
`ifdef WPORT_ARB_LOCK_EN
    // cnt_q counts grant cycles already spent by the locker, minus one.
    cnt_d = '0;
    if (state_q != ST_IDLE && req[sel_q] && lock[sel_q] &&
        !(state_q == ST_LOCKED && cnt_q == CNT_W'(LOCK_MAX - 1))) begin
      hold  = 1'b1;
      cnt_d = (state_q == ST_LOCKED) ? cnt_q + CNT_W'(1) : CNT_W'(1);
    end
`endif
    if (hold) begin
      state_d = ST_LOCKED;
      mux_idx = sel_q;
    end else if (pick_valid) begin
      state_d = ST_GRANT;
      ptr_d   = pick_idx + 2'd1;
    end else begin
      state_d = ST_IDLE;
    end
    if (hold || pick_valid) begin
      gnt_d     = 4'b0001 << mux_idx;
      sel_d     = mux_idx;
      wr_addr_d = addr_in[int'(mux_idx)*ADDR_W +: ADDR_W];
      wr_data_d = data_in[int'(mux_idx)*DATA_W +: DATA_W];
      wr_en_d   = |wr_addr_d;
      busy_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      sel_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
`ifdef WPORT_ARB_LOCK_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
`ifdef WPORT_ARB_LOCK_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_wport_arbiter_4.sv
// Randomized bench for wport_arbiter_4 against a cycle-level behavioural model.
module tb_wport_arbiter_4;

`ifdef WPORT_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req, lock;
  logic [19:0]  addr_in;
  logic [127:0] data_in;
  logic [3:0]   gnt;
  logic [1:0]   sel;
  logic         wr_en, busy;
  logic [4:0]   wr_addr;
  logic [31:0]  wr_data;

  int n_checks = 0;
  int n_errors = 0;

  // Model: holder = granted requester (-1 none), run = consecutive grant cycles.
  int m_holder, m_ptr, m_run;
  logic [3:0]  e_gnt;
  logic [1:0]  e_sel;
  logic        e_wr_en, e_busy;
  logic [4:0]  e_addr;
  logic [31:0] e_data;

  always #5 clk = ~clk;

  wport_arbiter_4 #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock),
    .addr_in(addr_in), .data_in(data_in),
    .gnt(gnt), .sel(sel), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update();
    bit keep;
    int w;
    if (reset) begin
      m_holder = -1; m_ptr = 0; m_run = 0;
      e_gnt = '0; e_sel = '0; e_wr_en = 1'b0; e_busy = 1'b0;
      e_addr = '0; e_data = '0;
      return;
    end
    keep = LOCK_EN && m_holder >= 0 && req[m_holder] && lock[m_holder] && m_run < 4;
    if (keep) begin
      m_run++;
    end else begin
      w = -1;
      for (int k = 0; k < 4; k++)
        if (w < 0 && req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
      m_holder = w;
      if (w >= 0) begin
        m_ptr = (w + 1) % 4;
        m_run = 1;
      end else begin
        m_run = 0;
      end
    end
    if (m_holder >= 0) begin
      e_gnt   = 4'(1 << m_holder);
      e_sel   = 2'(m_holder);
      e_addr  = addr_in[m_holder*5 +: 5];
      e_data  = data_in[m_holder*32 +: 32];
      e_wr_en = (e_addr != 0);
      e_busy  = 1'b1;
    end else begin
      e_gnt = '0; e_wr_en = 1'b0; e_busy = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_eq("gnt", 64'(gnt), 64'(e_gnt));
    check_eq("sel", 64'(sel), 64'(e_sel));
    check_eq("wr_en", 64'(wr_en), 64'(e_wr_en));
    check_eq("wr_addr", 64'(wr_addr), 64'(e_addr));
    check_eq("wr_data", 64'(wr_data), 64'(e_data));
    check_eq("busy", 64'(busy), 64'(e_busy));
  endtask

  task automatic rand_payload();
    for (int i = 0; i < 4; i++) begin
      addr_in[i*5 +: 5]   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      data_in[i*32 +: 32] = $urandom;
    end
  endtask

  initial begin
    reset = 1'b1; req = '0; lock = '0; addr_in = '0; data_in = '0;
    m_holder = -1; m_ptr = 0; m_run = 0;
    rand_payload();
    repeat (2) step();
    reset = 1'b0;

    // Rotation with all requesters active.
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      rand_payload();
      step();
      check_eq("rr_seq_gnt", 64'(gnt), 64'(4'b0001 << (k % 4)));
    end
    req = '0;
    step();
    check_eq("idle_busy", 64'(busy), 64'd0);

    // Single request with a known payload.
    req = 4'b0100;
    addr_in[10 +: 5] = 5'd17;
    data_in[64 +: 32] = 32'hDEAD_BEEF;
    step();
    check_eq("single_wr_data", 64'(wr_data), 64'h0000_0000_DEAD_BEEF);
    check_eq("single_wr_addr", 64'(wr_addr), 64'd17);
    req = '0;
    step();

    // Zero address consumes the grant without a write.
    req = 4'b0010;
    addr_in[5 +: 5] = 5'd0;
    step();
    check_eq("zero_addr_wr_en", 64'(wr_en), 64'd0);
    req = '0;
    step();

    // Locker competing with requester 1.
    req = 4'b0011; lock = 4'b0001;
    repeat (12) step();
    req = '0; lock = '0;
    step();

    // Reset in the middle of a locked sequence.
    req = 4'b1000; lock = 4'b1000;
    repeat (3) step();
    reset = 1'b1;
    step();
    check_eq("reset_gnt", 64'(gnt), 64'd0);
    reset = 1'b0;
    step();
    check_eq("post_reset_gnt", 64'(gnt), 64'(4'b1000));
    req = 4'b1111; lock = '0;
    step();
    check_eq("post_reset_ptr", 64'(gnt), 64'(4'b0001));

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      req   = 4'($urandom);
      lock  = ($urandom_range(0, 1) == 0) ? 4'($urandom) : req;
      reset = ($urandom_range(0, 199) == 0);
      rand_payload();
      step();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
